fact_operand_seq: RTL and testbench
===================================

FACT_OPERAND_SEQ -- requirements
Module: fact_operand_seq

Interface
REQ-001 The module SHALL expose parameter W, default 5, giving the operand width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a sequence, sampled only in IDLE.
REQ-005 The module SHALL have port n_in, input, W bits: factorial argument N, captured with start.
REQ-006 The module SHALL have port op_valid, output, 1 bit: op_data holds a valid operand.
REQ-007 The module SHALL have port op_ready, input, 1 bit: consumer accepts the operand.
REQ-008 The module SHALL have port op_data, output, W bits: current operand.
REQ-009 The module SHALL have port op_last, output, 1 bit: current operand is the final one in the sequence.
REQ-010 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-012 The module SHALL implement the FSM states IDLE, ISSUE and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture n_in into the down-counter and move the FSM to ISSUE; op_valid SHALL be high in the next cycle (1-cycle latency).
REQ-014 In ISSUE, op_valid SHALL be 1 and op_data SHALL equal the counter; for N>=1 the sequence SHALL be N, N-1, ..., 1.
REQ-015 For N=0, exactly one operand of value 1 SHALL be issued with op_last=1 (0! = 1).
REQ-016 op_last SHALL be 1 exactly when op_data=1 in ISSUE.
REQ-017 A transfer SHALL occur only on a rising edge with op_valid=1 and op_ready=1; on a non-last transfer the counter SHALL decrement by 1.
REQ-018 While op_valid=1 and op_ready=0, op_data and op_last SHALL hold stable.
REQ-019 A transfer with op_last=1 SHALL move the FSM to DONE and drop op_valid in the next cycle.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 start SHALL be ignored in ISSUE and DONE, and n_in SHALL be ignored outside the capture edge.
REQ-022 The counter SHALL never wrap: no decrement below 1, and the maximum N of 2^W-1 (31) SHALL be issued without overflow.
REQ-023 op_valid, op_last and done SHALL never be asserted in IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately, asynchronously and without any clock edge, force state=IDLE, counter=0, op_valid=0, op_data=0, op_last=0, busy=0 and done=0.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-026 After reset_n deasserts, the first start SHALL be accepted at the first rising edge.

Configuration
REQ-027 When macro FACT_SEQ_ABORT_EN is defined, the module SHALL add an input port abort, 1 bit.
REQ-028 With FACT_SEQ_ABORT_EN defined, abort=1 at a rising edge in ISSUE or DONE SHALL move the FSM to IDLE and clear op_valid, op_last and done in the next cycle, with no done pulse.
REQ-029 With FACT_SEQ_ABORT_EN defined, abort SHALL take priority over a simultaneous transfer; abort in IDLE SHALL have no effect.
REQ-030 With FACT_SEQ_ABORT_EN undefined, the abort port and its logic SHALL be absent and behaviour SHALL follow REQ-012 to REQ-023 only.

Verification
REQ-031 The bench SHALL drive n_in=4 and start for 1 cycle with op_ready=1 throughout -> op_data 4,3,2,1 on consecutive cycles, op_last only with 1, done pulse in the following cycle, busy falling with IDLE.
REQ-032 The bench SHALL drive n_in=3 with op_ready toggling 0,1 -> each operand held stable while op_ready=0, sequence 3,2,1 with no skips or duplicates.
REQ-033 The bench SHALL drive n_in=0 -> a single operand 1 with op_last=1, then done; n_in=31 -> 31 operands ending at 1 with no wrap.
REQ-034 The bench SHALL pulse start with n_in=7 during an n_in=5 sequence -> start ignored and the sequence continues 5..1.
REQ-035 The bench SHALL assert reset_n=0 while op_data=2 -> all outputs 0 immediately, no done pulse, and a following start with n_in=2 yields 2,1.
REQ-036 With FACT_SEQ_ABORT_EN defined, the bench SHALL assert abort while op_data=3 and op_ready=1 -> op_valid=0 next cycle, IDLE, no done pulse.

Source files
------------

// File: rtl/fact_operand_seq.sv
// Factorial operand sequencer: issues N, N-1, ..., 1 (or a single 1 for N=0) over a valid/ready handshake.
// Optional abort input is enabled by defining FACT_SEQ_ABORT_EN.
module fact_operand_seq #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] n_in,
`ifdef FACT_SEQ_ABORT_EN
   input  logic         abort,
`endif
   output logic         op_valid,
   input  logic         op_ready,
   output logic [W-1:0] op_data,
   output logic         op_last,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_t;

   state_t       state, state_nxt;
   logic [W-1:0] cnt, cnt_nxt;
   logic         xfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs decode straight from registered state so reset clears them without a clock edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_valid  = (state == ISSUE);
      op_data   = op_valid ? cnt : '0;
      op_last   = op_valid && (cnt == W'(1));
      busy      = (state != IDLE);
      done      = (state == DONE);
      xfer      = op_valid && op_ready;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               // 0! is issued as the single operand 1
               cnt_nxt   = (n_in == '0) ? W'(1) : n_in;
            end
         end
         ISSUE: begin
            if (xfer) begin
               if (op_last) state_nxt = DONE;
               else         cnt_nxt   = cnt - W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

`ifdef FACT_SEQ_ABORT_EN
      // Abort overrides any simultaneous transfer and suppresses the done pulse.
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         cnt_nxt   = cnt;
      end
`endif
   end

endmodule

// File: tb/tb_fact_operand_seq.sv
// Scoreboard bench for fact_operand_seq: expected operands are queued at start and popped per transfer.
// Define FACT_SEQ_ABORT_EN to also exercise the abort input.
module tb_fact_operand_seq;

   localparam int unsigned W = 5;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] n_in = '0;
   logic         op_valid;
   logic         op_ready = 1'b1;
   logic [W-1:0] op_data;
   logic         op_last;
   logic         busy;
   logic         done;
`ifdef FACT_SEQ_ABORT_EN
   logic         abort = 1'b0;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned done_cnt = 0;
   logic        toggle_ready = 1'b0;
   logic [W-1:0] exp_q[$];

   fact_operand_seq #(.W(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .n_in     (n_in),
`ifdef FACT_SEQ_ABORT_EN
      .abort    (abort),
`endif
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_data  (op_data),
      .op_last  (op_last),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // op_ready driver: constant 1, or alternating when toggle_ready is set
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_ready) op_ready = ~op_ready;
         else              op_ready = 1'b1;
      end
   end

   // Monitor: transfers happen at the next posedge when valid&&ready is seen here
   logic         stalled = 1'b0;
   logic [W-1:0] held_data;
   logic         held_last;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!busy) check("idle_quiet", {29'd0, op_valid, op_last, done}, 32'd0);
      if (op_valid && stalled) begin
         check("hold_data", op_data, held_data);
         check("hold_last", op_last, held_last);
      end
      if (op_valid && op_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_op", op_valid, 1'b0);
         end else begin
            check("op_data", op_data, exp_q[0]);
            check("op_last", op_last, exp_q.size() == 1);
            void'(exp_q.pop_front());
         end
      end
      stalled   = op_valid && !op_ready;
      held_data = op_data;
      held_last = op_last;
   end

   // Push expected operands, pulse start across one posedge, verify 1-cycle latency.
   task automatic launch(input logic [W-1:0] n);
      if (n == 0) exp_q.push_back(W'(1));
      else for (int i = int'(n); i >= 1; i--) exp_q.push_back(W'(i));
      n_in  = n;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_in  = W'($urandom);
      @(negedge clk);
      check("latency_valid", op_valid, 1'b1);
      check("first_op", op_data, (n == 0) ? 32'd1 : 32'(n));
   endtask

   // Wait (bounded) for done; returns negedges counted after the first valid cycle.
   task automatic wait_done(output int k);
      int d0;
      d0 = done_cnt;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", done, 1'b1);
      check("busy_in_done", busy, 1'b1);
      check("drained", exp_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_fall", busy, 1'b0);
      check("done_count", done_cnt - d0, 1);
   endtask

   task automatic wait_data(input logic [W-1:0] v);
      int k;
      k = 0;
      while (!(op_valid && op_data == v) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("reach_value", op_data, v);
   endtask

   int k;
   int d0;

   initial begin
      #1;
      check("rst_valid", op_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data", op_data, 0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;

      // n=4, ready always 1: start accepted at first edge after reset
      launch(4);
      wait_done(k);
      check("n4_cycles", k, 4);

      // n=3 with toggling ready
      @(negedge clk);
      toggle_ready = 1'b1;
      launch(3);
      wait_done(k);
      toggle_ready = 1'b0;

      // n=0 and n=31
      @(negedge clk);
      launch(0);
      wait_done(k);
      check("n0_cycles", k, 1);
      @(negedge clk);
      launch(31);
      wait_done(k);
      check("n31_cycles", k, 31);

      // start with n_in=7 during an n=5 sequence is ignored
      @(negedge clk);
      launch(5);
      @(negedge clk);
      n_in  = 7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k);
      repeat (2) @(negedge clk);
      check("no_restart", op_valid, 1'b0);

      // reset mid-sequence while op_data=2
      launch(4);
      wait_data(2);
      d0 = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", op_valid, 1'b0);
      check("async_data", op_data, 0);
      check("async_last", op_last, 1'b0);
      check("async_busy", busy, 1'b0);
      check("async_done", done, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #3;
      reset_n = 1'b1;
      check("no_done_reset", done_cnt - d0, 0);
      launch(2);
      wait_done(k);
      check("n2_cycles", k, 2);

`ifdef FACT_SEQ_ABORT_EN
      @(negedge clk);
      launch(5);
      wait_data(3);
      d0 = done_cnt;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_valid", op_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      // abort in IDLE has no effect on a following sequence
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      launch(1);
      wait_done(k);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
